// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared encodings and helpers for the multiply/divide unit
// Contents: md_op_e opcode encodings, md_state_e controller states,
// acc_mode_e commit modes, max_int helper for parameter math.
// Optional feature macro: MD_UNIT_MADD_EN (MADD/MADDU/MSUB/MSUBU decode in md_unit).
package md_pkg;

    typedef enum logic [3:0] {
        MD_NOP = 4'd0,
        MULT   = 4'd1,
        MULTU  = 4'd2,
        DIV    = 4'd3,
        DIVU   = 4'd4,
        MTHI   = 4'd5,
        MTLO   = 4'd6,
        MADD   = 4'd7,
        MADDU  = 4'd8,
        MSUB   = 4'd9,
        MSUBU  = 4'd10
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    // How the pending result is applied to {hi,lo} at commit.
    typedef enum logic [1:0] {
        ACC_LOAD = 2'd0,
        ACC_ADD  = 2'd1,
        ACC_SUB  = 2'd2
    } acc_mode_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - request/result bundle between pipeline and multiply/divide unit
// Signals: start, md_op[3:0], rs_data, rt_data (pipeline -> unit);
// busy, hi, lo (unit -> pipeline).
// Modports: master = pipeline side, slave = md_unit side.
interface md_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       md_op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, md_op, rs_data, rt_data,
        input  busy, hi, lo
    );

    modport slave (
        input  start, md_op, rs_data, rt_data,
        output busy, hi, lo
    );
endinterface

// File: rtl/md_latency_ctr.sv
// rtl/md_latency_ctr.sv - loadable down-counter that times a multi-cycle operation
// Ports: clk, reset (async active-low), load, load_val[CW-1:0] in;
// busy (counter non-zero), last (counter == 1, commit enable) out.
module md_latency_ctr #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          busy,
    output logic          last
);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign busy = (cnt_q != '0);
    assign last = (cnt_q == CW'(1));

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multiply/divide unit with HI/LO registers and fixed multi-cycle latency
// Ports: clk, reset (async active-low), md (md_unit_if.slave: start, md_op,
// rs_data, rt_data in; busy, hi, lo out).
// Optional feature macro: MD_UNIT_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic    clk,
    input  logic    reset,
    md_unit_if.slave md
);

    localparam int CW = $clog2(max_int(MULT_CYCLES, DIV_CYCLES)) + 1;
    localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    md_state_e          state_q, state_d;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [2*WIDTH-1:0] pend_q;
    acc_mode_e          pend_acc_q;

    logic               accept, launch, wr_hi, wr_lo, commit;
    logic               ctr_busy, ctr_last;
    logic [CW-1:0]      cycles;
    logic [2*WIDTH-1:0] res;
    acc_mode_e          res_acc;

    logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
    logic               div_zero, div_ovf;
    logic [WIDTH-1:0]   den_s, den_u, quo_s, rem_s, quo_u, rem_u;

    assign a_sx   = {{WIDTH{md.rs_data[WIDTH-1]}}, md.rs_data};
    assign b_sx   = {{WIDTH{md.rt_data[WIDTH-1]}}, md.rt_data};
    assign a_zx   = {{WIDTH{1'b0}}, md.rs_data};
    assign b_zx   = {{WIDTH{1'b0}}, md.rt_data};
    assign prod_s = $signed(a_sx) * $signed(b_sx);
    assign prod_u = a_zx * b_zx;

    assign div_zero = (md.rt_data == '0);
    assign div_ovf  = (md.rs_data == INT_MIN) && (md.rt_data == '1);

    // Divide-by-zero and INT_MIN/-1 take their own result paths; the divider
    // sees a harmless divisor of 1 in those cases so it never traps.
    assign den_s = (div_zero || div_ovf) ? WIDTH'(1) : md.rt_data;
    assign den_u = div_zero ? WIDTH'(1) : md.rt_data;
    assign quo_s = $signed(md.rs_data) / $signed(den_s);
    assign rem_s = $signed(md.rs_data) % $signed(den_s);
    assign quo_u = md.rs_data / den_u;
    assign rem_u = md.rs_data % den_u;

    // Start is only honoured in IDLE; while busy the request is dropped.
    assign accept = md.start && (state_q == IDLE);

    always_comb begin
        launch  = 1'b0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        cycles  = '0;
        res     = '0;
        res_acc = ACC_LOAD;
        case (md_op_e'(md.md_op))
            MULT: begin
                launch = 1'b1;
                cycles = MULT_N;
                res    = prod_s;
            end
            MULTU: begin
                launch = 1'b1;
                cycles = MULT_N;
                res    = prod_u;
            end
            DIV: begin
                launch = 1'b1;
                cycles = DIV_N;
                if (div_zero)     res = {md.rs_data, {WIDTH{1'b1}}};
                else if (div_ovf) res = {{WIDTH{1'b0}}, INT_MIN};
                else              res = {rem_s, quo_s};
            end
            DIVU: begin
                launch = 1'b1;
                cycles = DIV_N;
                if (div_zero) res = {md.rs_data, {WIDTH{1'b1}}};
                else          res = {rem_u, quo_u};
            end
            MTHI: wr_hi = 1'b1;
            MTLO: wr_lo = 1'b1;
`ifdef MD_UNIT_MADD_EN
            MADD: begin
                launch  = 1'b1;
                cycles  = MULT_N;
                res     = prod_s;
                res_acc = ACC_ADD;
            end
            MADDU: begin
                launch  = 1'b1;
                cycles  = MULT_N;
                res     = prod_u;
                res_acc = ACC_ADD;
            end
            MSUB: begin
                launch  = 1'b1;
                cycles  = MULT_N;
                res     = prod_s;
                res_acc = ACC_SUB;
            end
            MSUBU: begin
                launch  = 1'b1;
                cycles  = MULT_N;
                res     = prod_u;
                res_acc = ACC_SUB;
            end
`endif
            default: ;
        endcase
    end

    md_latency_ctr #(.CW(CW)) u_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (accept && launch),
        .load_val (cycles),
        .busy     (ctr_busy),
        .last     (ctr_last)
    );

    assign commit = (state_q == RUN) && ctr_last;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && launch) state_d = RUN;
            RUN:  if (ctr_last)         state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            pend_q     <= '0;
            pend_acc_q <= ACC_LOAD;
        end else begin
            state_q <= state_d;
            if (accept && launch) begin
                pend_q     <= res;
                pend_acc_q <= res_acc;
            end
            // Accumulation uses hi/lo as they stand at commit, not at launch.
            if (commit) begin
                case (pend_acc_q)
                    ACC_ADD: {hi_q, lo_q} <= {hi_q, lo_q} + pend_q;
                    ACC_SUB: {hi_q, lo_q} <= {hi_q, lo_q} - pend_q;
                    default: {hi_q, lo_q} <= pend_q;
                endcase
            end else begin
                if (accept && wr_hi) hi_q <= md.rs_data;
                if (accept && wr_lo) lo_q <= md.rs_data;
            end
        end
    end

    assign md.busy = ctr_busy;
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

endmodule
